// File: rtl/sun_pll_pkg.sv
// Shared types and ratio helpers for the PLL feedback divider.
package sun_pll_pkg;

    typedef enum logic [1:0] {
        OFF    = 2'd0,
        SETTLE = 2'd1,
        RUN    = 2'd2
    } fbdiv_state_t;

    // Ratios below 2 cannot form a high and a low phase, so they run as 2.
    function automatic int unsigned clamp_div(input int unsigned d);
        return (d < 32'd2) ? 32'd2 : d;
    endfunction

    // High phase gets the extra cycle for odd ratios.
    function automatic int unsigned div_hi(input int unsigned n);
        return (n + 32'd1) >> 1;
    endfunction

endpackage

// File: rtl/sun_pll_div_core.sv
// Divide-by-N counter: period counter, ratio latch, CK_FB and FB_PULSE generation.
module sun_pll_div_core
    import sun_pll_pkg::*;
#(
    parameter int DIV_W = 8
) (
    input  logic             ck,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [DIV_W-1:0] div,
    output logic             wrap,
    output logic             ck_fb,
    output logic             fb_pulse,
    output logic [DIV_W-1:0] div_act
);

    logic [DIV_W-1:0] cnt_r;
    logic [DIV_W-1:0] div_act_r;
    logic             ck_fb_r;
    logic             fb_pulse_r;

    logic [DIV_W-1:0] n_s;
    logic [DIV_W-1:0] hi_s;
    logic [DIV_W-1:0] cnt_inc_s;
    logic             wrap_s;

    assign n_s       = DIV_W'(clamp_div(32'(div)));
    assign hi_s      = DIV_W'(div_hi(32'(div_act_r)));
    assign cnt_inc_s = cnt_r + DIV_W'(1);
    assign wrap_s    = (cnt_r == (div_act_r - DIV_W'(1)));

    // Period counter; the requested ratio is only taken at a period boundary.
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r      <= {DIV_W{1'b0}};
            div_act_r  <= DIV_W'(2);
            ck_fb_r    <= 1'b0;
            fb_pulse_r <= 1'b0;
        end else if (!en) begin
            cnt_r      <= {DIV_W{1'b0}};
            div_act_r  <= DIV_W'(2);
            ck_fb_r    <= 1'b0;
            fb_pulse_r <= 1'b0;
        end else if (load || wrap_s) begin
            cnt_r      <= {DIV_W{1'b0}};
            div_act_r  <= n_s;
            ck_fb_r    <= 1'b1;
            fb_pulse_r <= 1'b1;
        end else begin
            cnt_r      <= cnt_inc_s;
            ck_fb_r    <= (cnt_inc_s < hi_s);
            fb_pulse_r <= 1'b0;
        end
    end

    assign wrap     = wrap_s;
    assign ck_fb    = ck_fb_r;
    assign fb_pulse = fb_pulse_r;
    assign div_act  = div_act_r;

endmodule

// File: rtl/sun_pll_fbdiv.sv
// PLL feedback divider top: startup sequencing OFF -> SETTLE -> RUN around the divide core.
module sun_pll_fbdiv
    import sun_pll_pkg::*;
#(
    parameter int DIV_W      = 8,
    parameter int SETTLE_CYC = 16
) (
    input  logic             ck,
    input  logic             rst_n,
    input  logic             pwrup,
    input  logic [DIV_W-1:0] div,
    output logic             ck_fb,
    output logic             fb_pulse,
    output logic             ready,
    output logic [DIV_W-1:0] div_act
);

    localparam int SETTLE_W = $clog2(SETTLE_CYC + 1);

    fbdiv_state_t        state_r;
    fbdiv_state_t        state_nxt_s;
    logic [SETTLE_W-1:0] settle_r;
    logic [SETTLE_W-1:0] settle_nxt_s;
    logic [SETTLE_W-1:0] settle_inc_s;
    logic                ready_r;
    logic                ready_nxt_s;
    logic                load_s;
    logic                wrap_s;

    assign settle_inc_s = settle_r + SETTLE_W'(1);

    // Next-state, settle counting and core load request.
    always_comb begin
        state_nxt_s  = state_r;
        settle_nxt_s = settle_r;
        load_s       = 1'b0;
        case (state_r)
            OFF: begin
                settle_nxt_s = {SETTLE_W{1'b0}};
                if (pwrup) begin
                    state_nxt_s = SETTLE;
                    load_s      = 1'b1;
                end else begin
                    state_nxt_s = OFF;
                end
            end
            SETTLE: begin
                if (!pwrup) begin
                    state_nxt_s  = OFF;
                    settle_nxt_s = {SETTLE_W{1'b0}};
                end else if (wrap_s) begin
                    settle_nxt_s = settle_inc_s;
                    if (settle_inc_s == SETTLE_W'(SETTLE_CYC)) begin
                        state_nxt_s = RUN;
                    end else begin
                        state_nxt_s = SETTLE;
                    end
                end else begin
                    state_nxt_s = SETTLE;
                end
            end
            RUN: begin
                if (!pwrup) begin
                    state_nxt_s  = OFF;
                    settle_nxt_s = {SETTLE_W{1'b0}};
                end else begin
                    state_nxt_s = RUN;
                end
            end
            default: begin
                state_nxt_s  = OFF;
                settle_nxt_s = {SETTLE_W{1'b0}};
            end
        endcase
        ready_nxt_s = (state_nxt_s == RUN);
    end

    // State, settle counter and READY registers.
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= OFF;
            settle_r <= {SETTLE_W{1'b0}};
            ready_r  <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            settle_r <= settle_nxt_s;
            ready_r  <= ready_nxt_s;
        end
    end

    // Core is held cleared whenever PWRUP is low, which also outranks a coincident wrap.
    sun_pll_div_core #(
        .DIV_W(DIV_W)
    ) u_core (
        .ck       (ck),
        .rst_n    (rst_n),
        .en       (pwrup),
        .load     (load_s),
        .div      (div),
        .wrap     (wrap_s),
        .ck_fb    (ck_fb),
        .fb_pulse (fb_pulse),
        .div_act  (div_act)
    );

    assign ready = ready_r;

endmodule

// File: tb/tb_sun_pll_fbdiv.sv
// Directed self-checking bench for sun_pll_fbdiv with SETTLE_CYC=4.
module tb_sun_pll_fbdiv;

    logic       ck;
    logic       rst_n;
    logic       pwrup;
    logic [7:0] div;
    logic       ck_fb;
    logic       fb_pulse;
    logic       ready;
    logic [7:0] div_act;

    int n_checks = 0;
    int n_pass   = 0;

    sun_pll_fbdiv #(
        .DIV_W      (8),
        .SETTLE_CYC (4)
    ) dut (
        .ck       (ck),
        .rst_n    (rst_n),
        .pwrup    (pwrup),
        .div      (div),
        .ck_fb    (ck_fb),
        .fb_pulse (fb_pulse),
        .ready    (ready),
        .div_act  (div_act)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    // Steps n edges, comparing CK_FB and FB_PULSE against MSB-first bit patterns.
    task automatic run_pat(input string tag, input int n, input logic [31:0] fb_exp,
                           input logic [31:0] pul_exp);
        for (int i = 0; i < n; i++) begin
            tick();
            check({tag, "_fb"}, 32'(ck_fb), 32'(fb_exp[n-1-i]));
            check({tag, "_pulse"}, 32'(fb_pulse), 32'(pul_exp[n-1-i]));
        end
    endtask

    task automatic check_off(input string tag);
        check({tag, "_ckfb"}, 32'(ck_fb), 32'd0);
        check({tag, "_pulse"}, 32'(fb_pulse), 32'd0);
        check({tag, "_ready"}, 32'(ready), 32'd0);
        check({tag, "_divact"}, 32'(div_act), 32'd2);
    endtask

    // Steps edges first..last after PWRUP, READY must rise exactly on edge 17.
    task automatic run_ready(input string tag, input int first, input int last);
        for (int e = first; e <= last; e++) begin
            tick();
            check(tag, 32'(ready), (e >= 17) ? 32'd1 : 32'd0);
        end
    endtask

    task automatic drop_pwrup();
        pwrup = 1'b0;
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        pwrup = 1'b0;
        div   = 8'd4;
        #12;
        check_off("reset_async");
        rst_n = 1'b1;
        tick();
        check_off("reset");

        // Basic divide by 4
        pwrup = 1'b1;
        run_pat("div4", 8, 32'b11001100, 32'b10001000);
        check("div4_act", 32'(div_act), 32'd4);
        drop_pwrup();
        check_off("div4_off");

        // Odd ratio and clamped ratios
        div   = 8'd5;
        pwrup = 1'b1;
        run_pat("div5", 10, 32'b1110011100, 32'b1000010000);
        check("div5_act", 32'(div_act), 32'd5);
        drop_pwrup();
        div   = 8'd0;
        pwrup = 1'b1;
        run_pat("div0", 6, 32'b101010, 32'b101010);
        check("div0_act", 32'(div_act), 32'd2);
        drop_pwrup();
        div   = 8'd1;
        pwrup = 1'b1;
        run_pat("div1", 4, 32'b1010, 32'b1010);
        check("div1_act", 32'(div_act), 32'd2);
        drop_pwrup();

        // Mid-period ratio change 4 -> 6 at cnt=1
        div   = 8'd4;
        pwrup = 1'b1;
        run_pat("chg_pre", 2, 32'b11, 32'b10);
        div = 8'd6;
        run_pat("chg_cur", 2, 32'b00, 32'b00);
        check("chg_act_old", 32'(div_act), 32'd4);
        run_pat("chg_new", 7, 32'b1110001, 32'b1000001);
        check("chg_act_new", 32'(div_act), 32'd6);
        drop_pwrup();
        check_off("chg_off");

        // READY timing with DIV=4
        div   = 8'd4;
        pwrup = 1'b1;
        run_ready("settle_ready", 1, 27);
        // edge 27 leaves cnt=2; drop PWRUP
        pwrup = 1'b0;
        tick();
        check_off("drop_run");

        // Re-assert, then drop on a cycle that would wrap
        pwrup = 1'b1;
        run_ready("reassert_ready", 1, 20);
        pwrup = 1'b0;
        tick();
        check_off("drop_wrap");

        // Async reset mid-RUN
        pwrup = 1'b1;
        run_ready("pre_rst_ready", 1, 18);
        check("pre_rst_ckfb", 32'(ck_fb), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_off("async_rst");
        tick();
        check_off("rst_hold");
        #2;
        rst_n = 1'b1;
        tick();
        check("restart_ckfb", 32'(ck_fb), 32'd1);
        check("restart_pulse", 32'(fb_pulse), 32'd1);
        check("restart_divact", 32'(div_act), 32'd4);
        check("restart_ready", 32'(ready), 32'd0);
        run_ready("restart_ready_seq", 2, 18);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
